hamming_nibble_packer: RTL and testbench
========================================

# hamming_nibble_packer

Downstream stage of the Hamming(7,4) encode/decode path. It accepts a stream of 7-bit codewords under a valid/ready handshake and corrects single-bit errors by syndrome. Corrected nibbles are packed in pairs (first nibble low, second nibble high) into bytes, which are presented on a registered valid/ready output. A flush input emits a trailing half-byte, and an optional block of statistics counters tracks corrections.

## Interface
Parameters:
- `CNT_W`, default 8: width of the saturating statistics counters.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `in_code` in 7: codeword; bit 0=p1, 1=p2, 2=d0, 3=p4, 4=d1, 5=d2, 6=d3.
- `in_valid` in 1: `in_code` is valid this cycle.
- `in_ready` out 1: packer accepts `in_code` this cycle.
- `flush` in 1: single-cycle request to emit a pending half-byte.
- `out_byte` out 8: packed data, {second nibble, first nibble}.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: consumer accepts `out_byte`.
- `out_corr` out 1: at least one nibble of `out_byte` was corrected.
- `out_partial` out 1: byte was produced by a flush; bits [7:4] are 0.
- `corr_cnt` out CNT_W: number of corrected codewords (present only with the stats macro).
- `word_cnt` out CNT_W: number of accepted codewords (present only with the stats macro).

## Operation
- Handshakes:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Syndrome and correction (combinational on `in_code`):
  - s[0] = c0^c2^c4^c6, s[1] = c1^c2^c5^c6, s[2] = c3^c4^c5^c6.
  - If s≠0, bit s−1 is inverted.
  - The nibble is {c6,c5,c4,c2}.
  - `corr` = (s≠0).
- FSM states:
  - EMPTY: no pending low nibble.
  - HALF: low nibble and its `corr` are held.
- EMPTY transitions:
  - Input transfer: store nibble and `corr`, go to HALF.
  - `in_ready` = 1 in EMPTY.
- HALF transitions:
  - `in_ready` = !out_valid || out_ready.
  - Input transfer: load the output register with {nibble, low}; `out_corr` = corr_low | corr; `out_partial` = 0; set `out_valid`; go to EMPTY.
- Flush:
  - `flush` in HALF with no input transfer in the same cycle, and with the output register free (!out_valid || out_ready): load {4'h0, low}, set `out_partial` = 1, go to EMPTY.
  - `flush` in HALF while the output register is blocked: the flush is ignored, not queued.
  - `flush` in EMPTY: no effect.
  - Input transfer and `flush` in the same cycle: the input transfer takes priority; the flush is dropped.
- Output register:
  - `out_valid` clears on an output transfer unless it is reloaded in the same cycle.
  - `out_byte`, `out_corr` and `out_partial` hold steady while `out_valid && !out_ready`.
- Double-bit errors are miscorrected as single-bit errors; no detection is provided.

## Timing
- Reset values: state EMPTY; `out_valid` 0; `out_byte` 8'h00; `out_corr` 0; `out_partial` 0; counters 0.
- `in_ready` is 1 during reset.
- Latency: `out_valid` rises one cycle after the accepting edge of the second nibble (or of the flush).
- Throughput: one codeword per cycle when `out_ready` is held 1. A byte is emitted every 2 cycles.
- `in_ready` depends combinationally on `out_ready` in HALF only; there is no path from `in_code` to `in_ready`.
- `rst` mid-operation: the pending half-byte and the output byte are discarded; nothing is emitted.

## Configuration
- `HAMMING_PACK_STATS_EN` defined:
  - `corr_cnt` increments on each input transfer with `corr` = 1.
  - `word_cnt` increments on each input transfer.
  - Both saturate at 2^CNT_W−1 and never wrap.
- `HAMMING_PACK_STATS_EN` undefined:
  - Counter logic and both counter ports are removed.
  - All other behaviour is identical.

## Test plan
- Reset, then codewords 0x55 followed by 0x2A, with `out_ready` = 1: `out_byte` = 0x4B, `out_corr` = 0, `out_partial` = 0, `out_valid` high for 1 cycle.
- Codewords 0x45 (0x55 with bit 4 flipped, s=5) followed by 0x2A: `out_byte` = 0x4B, `out_corr` = 1. With the stats macro, `corr_cnt` = 1 and `word_cnt` = 2.
- `out_ready` = 0 while streaming 0x55, 0x2A, 0x55, 0x2A: after the first byte, `in_ready` drops in HALF. `out_byte` holds 0x4B until `out_ready` = 1; no data is lost or duplicated.
- Codeword 0x55, then `flush`: `out_byte` = 0x0B, `out_partial` = 1. A `flush` in EMPTY produces no output.
- Codeword 0x55, then `rst` for 1 cycle, then 0x2A, 0x55: the output byte is {B, 4} = 0xB4 (the pre-reset nibble is dropped).
- With the stats macro and CNT_W = 2, send 5 corrupted codewords: `corr_cnt` reaches 3 and stays at 3.

Source files
------------

// File: rtl/hamming_nibble_packer.sv
// hamming_nibble_packer
//   Corrects single-bit errors in incoming Hamming(7,4) codewords and packs
//   the corrected nibbles in pairs (first nibble low) into bytes held in a
//   registered valid/ready output stage. A flush emits a trailing half-byte.
//   Optional statistics counters are enabled with HAMMING_PACK_STATS_EN.
module hamming_nibble_packer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_corr,
    output logic             out_partial
`ifdef HAMMING_PACK_STATS_EN
    ,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] word_cnt
`endif
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HALF  = 1'b1;

    logic [0:0] state;
    logic [3:0] low_nib;
    logic       low_corr;

    logic [2:0] syn;
    logic [6:0] flip;
    logic [6:0] fixed;
    logic [3:0] nib;
    logic       corr;
    logic       out_free;
    logic       in_xfer;

    // Syndrome decode and single-bit correction of the incoming codeword
    always_comb begin
        syn[0] = in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6];
        syn[1] = in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6];
        syn[2] = in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6];
        flip   = '0;
        if (syn != 3'd0) begin
            flip[syn - 3'd1] = 1'b1;
        end
        fixed = in_code ^ flip;
        nib   = {fixed[6], fixed[5], fixed[4], fixed[2]};
        corr  = (syn != 3'd0);
    end

    // Handshake qualifiers; in_ready never depends on in_code
    always_comb begin
        out_free = !out_valid || out_ready;
        in_ready = rst || (state == EMPTY) || out_free;
        in_xfer  = in_valid && in_ready;
    end

    // Pairing FSM and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            low_nib     <= '0;
            low_corr    <= 1'b0;
            out_byte    <= '0;
            out_valid   <= 1'b0;
            out_corr    <= 1'b0;
            out_partial <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        low_nib  <= nib;
                        low_corr <= corr;
                        state    <= HALF;
                    end
                end
                HALF: begin
                    // in_xfer in HALF already implies the output stage is free
                    if (in_xfer) begin
                        out_byte    <= {nib, low_nib};
                        out_corr    <= low_corr | corr;
                        out_partial <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= EMPTY;
                    end else if (flush && out_free) begin
                        out_byte    <= {4'h0, low_nib};
                        out_corr    <= low_corr;
                        out_partial <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef HAMMING_PACK_STATS_EN
    localparam cnt_t CNT_MAX = '1;

    // Saturating counters of accepted and corrected codewords
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_cnt <= '0;
            word_cnt <= '0;
        end else if (in_xfer) begin
            if (word_cnt != CNT_MAX) begin
                word_cnt <= word_cnt + cnt_t'(1);
            end
            if (corr && (corr_cnt != CNT_MAX)) begin
                corr_cnt <= corr_cnt + cnt_t'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hamming_nibble_packer.sv
// tb_hamming_nibble_packer
//   Directed test of hamming_nibble_packer. Stats checks are compiled only
//   when HAMMING_PACK_STATS_EN is defined (DUT built with CNT_W = 2).
module tb_hamming_nibble_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_corr;
    logic       out_partial;
`ifdef HAMMING_PACK_STATS_EN
    logic [1:0] corr_cnt;
    logic [1:0] word_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_nibble_packer #(.CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_code     (in_code),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_corr    (out_corr),
        .out_partial (out_partial)
`ifdef HAMMING_PACK_STATS_EN
        ,
        .corr_cnt    (corr_cnt),
        .word_cnt    (word_cnt)
`endif
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_code  = 7'h00;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_byte !== 8'h00) begin
            errors++; $display("FAIL reset_out_byte: got %h expected 00", out_byte);
        end
        checks++;
        if ({out_corr, out_partial} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: got %b expected 00", {out_corr, out_partial});
        end
`ifdef HAMMING_PACK_STATS_EN
        checks++;
        if ({corr_cnt, word_cnt} !== 4'h0) begin
            errors++; $display("FAIL reset_counters: got %h expected 0", {corr_cnt, word_cnt});
        end
`endif
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_basic_pair();
        do_reset();
        in_valid = 1'b1; in_code = 7'h55;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_first_no_out: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_half_ready: got %b expected 1", in_ready);
        end
        in_code = 7'h2A;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h4B) begin
            errors++; $display("FAIL basic_byte: got v=%b %h expected v=1 4b", out_valid, out_byte);
        end
        checks++;
        if ({out_corr, out_partial} !== 2'b00) begin
            errors++; $display("FAIL basic_flags: got %b expected 00", {out_corr, out_partial});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_valid_one_cycle: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_correction();
        do_reset();
        // 0x45: bit 4 of 0x55 flipped, corrected back to nibble B
        in_valid = 1'b1; in_code = 7'h45;
        tick();
        in_code = 7'h2A;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h4B || out_corr !== 1'b1) begin
            errors++; $display("FAIL corr_low: got v=%b %h c=%b expected v=1 4b c=1",
                               out_valid, out_byte, out_corr);
        end
`ifdef HAMMING_PACK_STATS_EN
        checks++;
        if (corr_cnt !== 2'd1 || word_cnt !== 2'd2) begin
            errors++; $display("FAIL corr_counters: got corr=%0d word=%0d expected corr=1 word=2",
                               corr_cnt, word_cnt);
        end
`endif
        // 0x2B: bit 0 of 0x2A flipped (s=1), error in the high nibble only
        in_valid = 1'b1; in_code = 7'h55;
        tick();
        in_code = 7'h2B;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h4B || out_corr !== 1'b1) begin
            errors++; $display("FAIL corr_high: got v=%b %h c=%b expected v=1 4b c=1",
                               out_valid, out_byte, out_corr);
        end
        // 0x15: bit 6 of 0x55 flipped (s=7), nibble B
        in_valid = 1'b1; in_code = 7'h2A;
        tick();
        in_code = 7'h15;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_byte !== 8'hB4 || out_corr !== 1'b1) begin
            errors++; $display("FAIL corr_bit6: got %h c=%b expected b4 c=1", out_byte, out_corr);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1; in_code = 7'h55;
        tick();
        in_code = 7'h2A;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h4B) begin
            errors++; $display("FAIL b2b_first: got v=%b %h expected v=1 4b", out_valid, out_byte);
        end
        in_code = 7'h2A;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_gap: got %b expected 0", out_valid);
        end
        in_code = 7'h55;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'hB4) begin
            errors++; $display("FAIL b2b_second: got v=%b %h expected v=1 b4", out_valid, out_byte);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 7'h55;
        tick();
        in_code = 7'h2A;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h4B) begin
            errors++; $display("FAIL bp_first: got v=%b %h expected v=1 4b", out_valid, out_byte);
        end
        in_code = 7'h2A;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty_ready: got %b expected 1", in_ready);
        end
        tick();
        in_code = 7'h55;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_half_blocked: got %b expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h4B) begin
            errors++; $display("FAIL bp_hold: got v=%b %h expected v=1 4b", out_valid, out_byte);
        end
        // Flush while blocked must be ignored, not queued
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_byte !== 8'h4B || out_partial !== 1'b0) begin
            errors++; $display("FAIL bp_flush_ignored: got %h p=%b expected 4b p=0",
                               out_byte, out_partial);
        end
        in_valid = 1'b1; in_code = 7'h55; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_follows: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'hB4 || out_partial !== 1'b0) begin
            errors++; $display("FAIL bp_second: got v=%b %h p=%b expected v=1 b4 p=0",
                               out_valid, out_byte, out_partial);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain: got %b expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_code = 7'h55;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'h0B || out_partial !== 1'b1 || out_corr !== 1'b0) begin
            errors++; $display("FAIL flush_half: got v=%b %h p=%b c=%b expected v=1 0b p=1 c=0",
                               out_valid, out_byte, out_partial, out_corr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_one_cycle: got %b expected 0", out_valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_empty: got %b expected 0", out_valid);
        end
        // Corrected half-byte keeps its corr flag
        in_valid = 1'b1; in_code = 7'h45;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_byte !== 8'h0B || out_corr !== 1'b1 || out_partial !== 1'b1) begin
            errors++; $display("FAIL flush_corr: got %h c=%b p=%b expected 0b c=1 p=1",
                               out_byte, out_corr, out_partial);
        end
        tick();
        // Input and flush together: input wins, flush dropped
        in_valid = 1'b1; in_code = 7'h2A;
        tick();
        in_code = 7'h55; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (out_byte !== 8'hB4 || out_partial !== 1'b0) begin
            errors++; $display("FAIL flush_priority: got %h p=%b expected b4 p=0", out_byte, out_partial);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_after_priority: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 7'h55;
        tick();
        in_code = 7'h2A;
        tick();
        in_code = 7'h55;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_blocked: got %b expected 0", in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_ready_in_reset: got %b expected 1", in_ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_byte !== 8'h00) begin
            errors++; $display("FAIL mid_discard: got v=%b %h expected v=0 00", out_valid, out_byte);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_code = 7'h2A;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_no_stale: got %b expected 0", out_valid);
        end
        in_code = 7'h55;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'hB4) begin
            errors++; $display("FAIL mid_byte: got v=%b %h expected v=1 b4", out_valid, out_byte);
        end
        tick();
    endtask

`ifdef HAMMING_PACK_STATS_EN
    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; in_code = 7'h45;
        tick();
        tick();
        checks++;
        if (corr_cnt !== 2'd2 || word_cnt !== 2'd2) begin
            errors++; $display("FAIL sat_partial: got corr=%0d word=%0d expected 2 2", corr_cnt, word_cnt);
        end
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (corr_cnt !== 2'd3 || word_cnt !== 2'd3) begin
            errors++; $display("FAIL sat_hold: got corr=%0d word=%0d expected 3 3", corr_cnt, word_cnt);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_pair();
        test_correction();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_mid_reset();
`ifdef HAMMING_PACK_STATS_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
